mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
Sequences the 8x8 Multiplier unit in the RISC240 datapath on behalf of the controlpath FSM. On a multiply request it latches the 8-bit operands and issues a one-cycle start pulse. It then waits for done, with a watchdog, and performs a single-cycle writeback. The writeback drives the result-mux select, the register-file load and the condition-code load. The controlpath stalls on busy instead of tracking multiplier timing itself.

Parameters:
WIDTH, 8, operand width; product is 2*WIDTH
TIMEOUT, 32, maximum WAIT cycles before declaring a hung multiplier (TIMEOUT >= 2)

Ports:
clock  input  1  system clock
reset_L  input  1  asynchronous active-low reset
mul_req  input  1  request from controlpath; sampled only in IDLE
srcA  input  WIDTH  operand A (aluSrcA low bits)
srcB  input  WIDTH  operand B (aluSrcB low bits)
clear_err  input  1  clears sticky timeout_err
mul_done  input  1  Multiplier done
mul_out  input  2*WIDTH  Multiplier product
mul_flags  input  2  Multiplier flags; [0]=Z, [1]=N
mul_start  output  1  one-cycle start pulse to Multiplier
mul_abort  output  1  one-cycle synchronous clear to Multiplier after timeout
mul_a  output  WIDTH  latched operand A
mul_b  output  WIDTH  latched operand B
busy  output  1  stall to controlpath
result_sel  output  1  selects product onto result bus
load_rd_L  output  1  active-low register-file write of result
lcc_L  output  1  active-low condition-code load
product  output  2*WIDTH  latched product
cc_out  output  4  {Z,N,C,V} = {flag0,flag1,0,0}
timeout_err  output  1  sticky watchdog error
op_count  output  16  completed multiplies, wraps at 16'hFFFF→0

Behaviour:
- Reset (async, reset_L=0) sets the following values:
  - state=IDLE.
  - mul_start=0, mul_abort=0, busy=0, result_sel=0.
  - load_rd_L=1, lcc_L=1.
  - mul_a, mul_b, product, cc_out and op_count = 0.
  - timeout_err=0.
  - Reset mid-operation abandons the operation with no writeback.
- States are IDLE, LAUNCH, WAIT, WRITEBACK, ERROR.
- IDLE:
  - busy=0.
  - On mul_req=1 at a clock edge: latch mul_a<=srcA and mul_b<=srcB, then go to LAUNCH.
  - mul_done in IDLE is ignored.
- LAUNCH:
  - mul_start=1 for exactly this cycle.
  - Watchdog counter cleared to 0; go to WAIT.
  - busy=1 from LAUNCH through WRITEBACK and ERROR.
- WAIT:
  - mul_start=0 and the counter increments each cycle.
  - If mul_done=1: latch product<=mul_out and cc_out<={mul_flags[0],mul_flags[1],2'b00}, then go to WRITEBACK.
  - Else, if counter==TIMEOUT-1: go to ERROR.
  - If done and timeout coincide, done wins.
- WRITEBACK (exactly one cycle):
  - result_sel=1, load_rd_L=0, lcc_L=0.
  - op_count increments; go to IDLE.
- ERROR (one cycle):
  - mul_abort=1 and timeout_err<=1; go to IDLE.
  - No writeback and no op_count change.
- timeout_err is sticky:
  - It is cleared by clear_err=1 at a clock edge.
  - Setting wins if ERROR and clear_err coincide.
- Latency: with req at edge 0, start is high in cycle 1. If done is seen in cycle k, writeback occurs in cycle k+1, and busy falls in cycle k+2.
- Back-to-back: mul_req held high re-launches from the first IDLE cycle after writeback. A request during busy is ignored, not queued.
- mul_a/mul_b are stable from LAUNCH until the next accepted request.
- Outputs are combinational from state only; there is no input-to-output combinational path.

Decomposition:
- State enum mul_seq_state_t and the CC bit-index constants (CC_Z=3, CC_N=2, CC_C=1, CC_V=0) go in the shared constants package alongside the controlPts struct.
- One sub-module is natural: mul_watchdog.
  - It is a clearable up-counter with a terminal-count output at TIMEOUT-1.
  - It is instantiated once.

Test Plan:
1. Reset then request srcA=8'd12, srcB=8'd10; multiplier model raises done 4 cycles after start with out=16'd120, flags=2'b00. Expect:
   - mul_start high exactly one cycle.
   - One WRITEBACK cycle with product=120, cc_out=4'b0000, load_rd_L=0, lcc_L=0, result_sel=1.
   - op_count=1; busy low two cycles after done.
2. srcA=0, srcB=8'd55; done with out=0, flags=2'b01. Expect cc_out=4'b1000 and writeback of 0.
3. Multiplier never asserts done, TIMEOUT=32. Expect:
   - ERROR entered after 32 WAIT cycles, with one mul_abort pulse.
   - timeout_err=1 and no load_rd_L pulse; op_count unchanged.
   - clear_err pulse returns timeout_err to 0.
4. Done arrives in the same cycle the counter hits TIMEOUT-1. Expect a normal writeback and timeout_err stays 0.
5. Request with mul_req held high for 3 consecutive operations, plus a spurious mul_done in IDLE and a change to srcA during WAIT. Expect:
   - Three writebacks; the spurious done is ignored.
   - mul_a unchanged during WAIT; op_count=3.
6. Assert reset_L=0 asynchronously mid-WAIT (between edges). Expect all outputs at their reset values immediately, no writeback, and a clean restart on the next request.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// rtl/mul_sequencer_pkg.sv - shared types and constants for the multiplier sequencer
// State encoding, condition-code bit positions and the control-point bundle.
package mul_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITEBACK,
    ST_ERROR
  } mul_seq_state_t;

  localparam int CC_Z = 3;
  localparam int CC_N = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  typedef struct packed {
    logic mul_start;
    logic mul_abort;
    logic busy;
    logic result_sel;
    logic load_rd_L;
    logic lcc_L;
  } control_pts_t;

  // Control points are a pure function of state, so the controlpath sees no input-to-output path.
  function automatic control_pts_t ctrl_for_state(input mul_seq_state_t st);
    control_pts_t c;
    c.mul_start  = 1'b0;
    c.mul_abort  = 1'b0;
    c.busy       = 1'b1;
    c.result_sel = 1'b0;
    c.load_rd_L  = 1'b1;
    c.lcc_L      = 1'b1;
    case (st)
      ST_IDLE:      c.busy = 1'b0;
      ST_LAUNCH:    c.mul_start = 1'b1;
      ST_WAIT:      c.busy = 1'b1;
      ST_WRITEBACK: begin
        c.result_sel = 1'b1;
        c.load_rd_L  = 1'b0;
        c.lcc_L      = 1'b0;
      end
      ST_ERROR:     c.mul_abort = 1'b1;
      default:      c.busy = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] pack_cc(input logic [1:0] flags);
    logic [3:0] cc;
    cc       = 4'b0000;
    cc[CC_Z] = flags[0];
    cc[CC_N] = flags[1];
    return cc;
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// rtl/mul_watchdog.sv - clearable up-counter flagging TIMEOUT-1 for the multiplier wait
// Clear has priority over count; the terminal flag is decoded from the registered count.
module mul_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clock,
  input  logic reset_L,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - launches the 8x8 multiplier, waits with a watchdog, writes back once
// The controlpath stalls on busy; requests seen while busy are dropped, not queued.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               mul_req,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  input  logic               clear_err,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_out,
  input  logic [1:0]         mul_flags,
  output logic               mul_start,
  output logic               mul_abort,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               busy,
  output logic               result_sel,
  output logic               load_rd_L,
  output logic               lcc_L,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         cc_out,
  output logic               timeout_err,
  output logic [15:0]        op_count
);

  mul_seq_state_t state_q, state_d;
  control_pts_t   ctrl;
  logic           wd_tc;

  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [3:0]         cc_q, cc_d;
  logic               timeout_err_q, timeout_err_d;
  logic [15:0]        op_count_q, op_count_d;

  mul_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset_L(reset_L),
    .clr    (state_q == ST_LAUNCH),
    .en     (state_q == ST_WAIT),
    .tc     (wd_tc)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Done is checked before the watchdog so a completion on the last allowed cycle is kept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (mul_req) state_d = ST_LAUNCH;
      ST_LAUNCH:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_done) begin
          state_d = ST_WRITEBACK;
        end else if (wd_tc) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITEBACK: state_d = ST_IDLE;
      ST_ERROR:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl       = ctrl_for_state(state_q);
    mul_start  = ctrl.mul_start;
    mul_abort  = ctrl.mul_abort;
    busy       = ctrl.busy;
    result_sel = ctrl.result_sel;
    load_rd_L  = ctrl.load_rd_L;
    lcc_L      = ctrl.lcc_L;
  end

  always_comb begin
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    product_d     = product_q;
    cc_d          = cc_q;
    timeout_err_d = timeout_err_q;
    op_count_d    = op_count_q;
    if (state_q == ST_IDLE && mul_req) begin
      mul_a_d = srcA;
      mul_b_d = srcB;
    end
    if (state_q == ST_WAIT && mul_done) begin
      product_d = mul_out;
      cc_d      = pack_cc(mul_flags);
    end
    if (state_q == ST_WRITEBACK) begin
      op_count_d = op_count_q + 16'd1;
    end
    if (state_q == ST_ERROR) begin
      timeout_err_d = 1'b1;
    end else if (clear_err) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      product_q     <= '0;
      cc_q          <= '0;
      timeout_err_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      product_q     <= product_d;
      cc_q          <= cc_d;
      timeout_err_q <= timeout_err_d;
      op_count_q    <= op_count_d;
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign product     = product_q;
  assign cc_out      = cc_q;
  assign timeout_err = timeout_err_q;
  assign op_count    = op_count_q;

endmodule
